// File: rtl/usb_cdc_rx_pkg.sv
// Shared types and defaults for the USB CDC receive buffer.
package usb_cdc_rx_pkg;
  localparam int ASIZE_DEF     = 10;
  localparam int AFULL_LVL_DEF = 960;
  localparam int OVF_CNT_W     = 16;

  typedef logic [7:0] byte_t;
endpackage

// File: rtl/usb_cdc_rx_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
// A read and write to the same address at the same edge returns the old data.
module usb_cdc_rx_ram
  import usb_cdc_rx_pkg::*;
#(
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [ASIZE-1:0] waddr_i,
  input  byte_t            wdata_i,
  input  logic [ASIZE-1:0] raddr_i,
  output byte_t            rdata_o
);

  byte_t mem_q [2**ASIZE];

  // Write port plus registered read port.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/usb_cdc_rx_buffer.sv
// Receive (host-to-device) byte buffer for the USB CDC device.
// Captures the core's unthrottled OUT byte stream into a 2^ASIZE FIFO and
// presents it to the user through a one-entry valid/ready output register.
// Optional feature: define USB_CDC_RX_OVF_CNT_EN to build the 16-bit
// saturating dropped-byte counter; otherwise ovf_count is tied to 0.
module usb_cdc_rx_buffer
  import usb_cdc_rx_pkg::*;
#(
  parameter int ASIZE     = ASIZE_DEF,
  parameter int AFULL_LVL = AFULL_LVL_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 usb_rstn,
  input  logic [7:0]           out_data,
  input  logic                 out_valid,
  output logic [7:0]           recv_data,
  output logic                 recv_valid,
  input  logic                 recv_ready,
  output logic [ASIZE:0]       level,
  output logic                 almost_full,
  output logic                 overflow,
  input  logic                 ovf_clr,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  localparam logic [ASIZE:0] AFULL_C = (ASIZE+1)'(AFULL_LVL);
  localparam logic [ASIZE:0] ONE_C   = (ASIZE+1)'(1);

  logic [ASIZE:0] wptr_q, wptr_d;
  logic [ASIZE:0] rptr_q, rptr_d;
  logic           flush, full, empty;
  logic           wr_en, drop, load;
  logic           ram_ok_q, ram_ok_d;
  byte_t          ram_rdata;
  byte_t          recv_data_q;
  logic           recv_valid_q;
  logic           afull_q;
  logic           ovf_q;

  // Pointer arithmetic, flags and the output-stage load decision.
  // The RAM is read at the next-state read pointer every cycle, so its output
  // always holds the byte at rptr_q. ram_ok_q marks that this prefetched byte
  // was already in RAM when it was read (it is not the slot being written at
  // that same edge); it costs one cycle only when the FIFO was just empty.
  always_comb begin
    flush    = rst | ~usb_rstn;
    empty    = (wptr_q == rptr_q);
    full     = (wptr_q[ASIZE] != rptr_q[ASIZE]) &&
               (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]);
    wr_en    = out_valid & ~full & ~flush;
    drop     = out_valid &  full & ~flush;
    load     = ram_ok_q & ~empty & (~recv_valid_q | recv_ready) & ~flush;
    wptr_d   = flush ? '0 : (wr_en ? wptr_q + ONE_C : wptr_q);
    rptr_d   = flush ? '0 : (load  ? rptr_q + ONE_C : rptr_q);
    ram_ok_d = ~flush & (rptr_d != wptr_q);
  end

  // Pointer and prefetch-valid registers; bus reset flushes like rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      ram_ok_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      ram_ok_q <= ram_ok_d;
    end
  end

  usb_cdc_rx_ram #(.ASIZE(ASIZE)) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wptr_q[ASIZE-1:0]),
    .wdata_i (out_data),
    .raddr_i (rptr_d[ASIZE-1:0]),
    .rdata_o (ram_rdata)
  );

  // Output register: load from RAM when free or being consumed, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      recv_valid_q <= 1'b0;
      recv_data_q  <= '0;
    end else if (!usb_rstn) begin
      recv_valid_q <= 1'b0;
    end else if (load) begin
      recv_valid_q <= 1'b1;
      recv_data_q  <= ram_rdata;
    end else if (recv_ready) begin
      recv_valid_q <= 1'b0;
    end
  end

  assign level = wptr_q - rptr_q;

  // Almost-full flag, one cycle behind level.
  always_ff @(posedge clk) begin
    if (flush) afull_q <= 1'b0;
    else       afull_q <= (level >= AFULL_C);
  end

  // Sticky overflow; a clear in the same cycle as a drop wins.
  always_ff @(posedge clk) begin
    if (rst || ovf_clr) ovf_q <= 1'b0;
    else if (drop)      ovf_q <= 1'b1;
  end

`ifdef USB_CDC_RX_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] ovf_cnt_q;

  // Saturating dropped-byte counter; survives a USB bus reset.
  always_ff @(posedge clk) begin
    if (rst || ovf_clr)                ovf_cnt_q <= '0;
    else if (drop && (ovf_cnt_q != '1)) ovf_cnt_q <= ovf_cnt_q + 1'b1;
  end

  assign ovf_count = ovf_cnt_q;
`else
  assign ovf_count = '0;
`endif

  assign recv_data   = recv_data_q;
  assign recv_valid  = recv_valid_q;
  assign almost_full = afull_q;
  assign overflow    = ovf_q;

endmodule

// File: doc/usb_cdc_rx_buffer.md
# usb_cdc_rx_buffer

Receive-side (host-to-device) buffer for the USB CDC device. It captures the unthrottled byte stream the USB full-speed core emits on `out_data`/`out_valid`, stores it in a 2^ASIZE-byte FIFO, and hands it to user logic through a valid/ready handshake. Bytes arriving while the FIFO is full are dropped and reported. It is the read-side counterpart of the existing 1024-byte send buffer and sits between the core's OUT endpoint and the application.

## Interface
- ASIZE, 10: FIFO address width; depth = 2^ASIZE bytes.
- AFULL_LVL, 960: `almost_full` asserts when `level` ≥ AFULL_LVL; must be ≤ 2^ASIZE.
- clk  in  1  system clock, 60 MHz, same clock as the USB core.
- rst  in  1  reset, synchronous, active-high.
- usb_rstn  in  1  bus-reset indication from the core, sampled synchronously; 0 flushes the FIFO.
- out_data  in  8  byte from the core.
- out_valid  in  1  single-cycle strobe; no backpressure toward the core.
- recv_data  out  8  byte presented to the user.
- recv_valid  out  1  `recv_data` is valid.
- recv_ready  in  1  user accepts the byte when `recv_valid & recv_ready`.
- level  out  ASIZE+1  bytes held in RAM, `wptr-rptr`; excludes the output stage.
- almost_full  out  1  registered, `level ≥ AFULL_LVL`.
- overflow  out  1  sticky; set on the first dropped byte.
- ovf_clr  in  1  clears `overflow` and `ovf_count`.
- ovf_count  out  16  saturating count of dropped bytes.

## Operation
- Pointers `wptr`/`rptr` are ASIZE+1 bits wide.
  - full = MSBs differ and the low bits are equal.
  - empty = pointers equal.
  - Both flags are evaluated from the registered pointers.
- Write: `out_valid & ~full` stores `out_data` at `wptr[ASIZE-1:0]` and increments `wptr`.
- Drop: `out_valid & full` discards the byte, sets `overflow`, and increments `ovf_count`, which saturates at 0xFFFF.
- Read path: RAM with one-cycle registered read, followed by a single output register (`recv_data`/`recv_valid`).
  - The output stage loads when it is empty or being consumed, and RAM is not empty.
  - `rptr` increments on each load.
  - `recv_data` is held stable while `recv_valid & ~recv_ready`.
- Simultaneous write and load in the same cycle: both occur; `level` is unchanged.
- Full with a simultaneous load: the write is still dropped, because full is taken from the pre-edge pointers.
- Wrap-around: the pointers roll over naturally, and the MSB toggle distinguishes full from empty.
- Flush: `rst=1` or `usb_rstn=0`.
  - Pointers are zeroed and `recv_valid` goes to 0.
  - `overflow` and `ovf_count` are cleared only by `rst` or `ovf_clr`, so they survive a USB bus reset.
  - If `out_valid` arrives during a flush, the byte is ignored.
- `ovf_clr` coinciding with a drop: the clear wins, and the count ends at 0.

## Timing
- Reset values: `recv_valid=0`, `recv_data=0`, `level=0`, `almost_full=0`, `overflow=0`, `ovf_count=0`.
- Latency: a byte written at edge N into an empty FIFO with an idle output stage appears as `recv_valid=1` after edge N+2.
- Sustained throughput: 1 byte/cycle when `recv_ready` is held high.
- `level` updates at the same edge as the pointer change.
- `almost_full` lags `level` by one cycle.
- `overflow` is set at the edge of the dropping `out_valid`.

## Configuration
- `USB_CDC_RX_OVF_CNT_EN`
  - Defined: the 16-bit saturating `ovf_count` is implemented as described.
  - Undefined: the counter logic is removed and `ovf_count` is tied to 0. `overflow` and `ovf_clr` behave identically in both builds.

## Structure
- Package `usb_cdc_rx_pkg` holds:
  - the default ASIZE and AFULL_LVL;
  - `OVF_CNT_W = 16`;
  - `typedef logic [7:0] byte_t`.
- Sub-module `usb_cdc_rx_ram`: simple dual-port RAM (one write port, one registered read port), inferable to BRAM.
- Pointer, flag, output-stage and overflow logic live in the top module.

## Test plan
- Single byte: `out_valid` with 0x5A into an empty FIFO, `recv_ready=1` → `recv_valid` two cycles later with `recv_data=0x5A` for one cycle; `level` returns to 0.
- Backpressure: write 0x01..0x10 with `recv_ready=0` → `recv_valid` held with data 0x01 and `level=15`. Then raise `recv_ready` → 0x01..0x10 delivered in order on consecutive cycles.
- Overflow: with ASIZE=4 and `recv_ready=0`, write 20 bytes → `level=16`, `overflow=1`, `ovf_count=3`. Data read back is bytes 1..17.
- Wrap-around: with ASIZE=4, stream 100 bytes with randomly toggled `recv_ready` → all 100 bytes received in order, with no `overflow`.
- Flush: fill 8 bytes, pulse `usb_rstn=0` for 1 cycle → `recv_valid=0`, `level=0`; `overflow` is unchanged. Pulse `ovf_clr` → `overflow=0`, `ovf_count=0`.
- Saturation (macro defined): force 70000 drops → `ovf_count=0xFFFF`. Without the macro → `ovf_count=0` and `overflow=1`.
